bit_unstuff_crc16_rx: RTL and testbench
=======================================

// Module: bit_unstuff_crc16_rx
// PURPOSE
//  Receive-side counterpart of the transmit CRC16 encoder + bit stuffer.
//  Takes the NRZI-decoded serial stream of a DATA packet body (payload + CRC16 field, PID already stripped).
//  Removes stuffed bits, checks USB CRC16 (x^16+x^15+x^2+1) and deserialises the payload.
//  Reports one status pulse per packet to the protocol handler.
// PARAMETERS
//  DATA_BITS  64  payload width in bits; the CRC field is fixed at 16 bits; must be >=8
// PORTS
//  clock      in   1          system clock, all state on posedge
//  reset_n    in   1          asynchronous, active-low reset
//  in_bit     in   1          decoded bus bit, qualified by in_valid
//  in_valid   in   1          in_bit is a new bus bit this cycle
//  in_eop     in   1          1-cycle pulse: end of packet seen on bus
//  pkt_out    out  DATA_BITS  received payload, first received bit in pkt_out[0]
//  rx_busy    out  1          packet reception in progress (RECV or ERR)
//  rx_done    out  1          1-cycle pulse: packet finished, status below valid this cycle
//  crc_ok     out  1          residual == 16'h800D (meaningful only with rx_done)
//  stuff_err  out  1          a stuffed-bit position carried a 1
//  len_err    out  1          accepted bit count != DATA_BITS+16
// BEHAVIOUR
//  Reset: state=IDLE, ones_cnt=0, bit_cnt=0, crc=16'hFFFF, sr=0.
//   All outputs reset to 0, including pkt_out.
//  FSM states: IDLE, RECV, ERR.
//  - IDLE -> RECV on in_valid; that bit is processed in the same cycle. Entering RECV re-inits crc, counters and status flags.
//  - RECV -> ERR on stuff error, or on an accepted bit when bit_cnt==DATA_BITS+16 (len_err).
//  - RECV or ERR -> IDLE on in_eop.
//  Unstuffing (per in_valid in RECV):
//  - If ones_cnt==6, the bit is a stuffed bit. A 0 is dropped and sets ones_cnt=0. A 1 sets stuff_err -> ERR.
//  - Otherwise the bit is accepted: ones_cnt = bit ? ones_cnt+1 : 0.
//  Accepted bit:
//  - sr (DATA_BITS+16 wide) <= {bit, sr[MSB:1]}; bit_cnt++ (saturates at DATA_BITS+17).
//  - fb = crc[15]^bit; crc <= {crc[14:0],1'b0} ^ (fb ? 16'h8005 : 0).
//  - After a full packet, sr[DATA_BITS-1:0] holds the payload and sr[MSB:DATA_BITS] holds the CRC field.
//  ERR: ignores in_valid; waits for in_eop.
//  in_eop handling:
//  - Next cycle: rx_done=1 for 1 cycle.
//  - len_err = (bit_cnt != DATA_BITS+16) | earlier length overflow.
//  - crc_ok = !len_err & !stuff_err & (crc==16'h800D).
//  - pkt_out <= sr[DATA_BITS-1:0] only when crc_ok, else it holds its previous value.
//  in_eop while IDLE (zero bits) produces rx_done with len_err=1.
//  Simultaneous in_valid & in_eop: the bit is processed first, then EOP is evaluated with the updated counts/crc.
//   In IDLE, the bit starts and ends the packet (len_err=1).
//  crc_ok/stuff_err/len_err hold their values until the next packet enters RECV.
//  rx_busy=1 in RECV and ERR.
//  Latency: rx_done is exactly 1 cycle after in_eop.
//  Gaps between in_valid bits of any length are legal.
//  reset_n low mid-packet: aborts immediately to reset values, with no rx_done.
//   The next in_valid after reset starts a fresh packet.
// TESTING
//  1. Good packet: payload 64'h40aa11b7682df6d8 + CRC 16'h544a, stuffed and serialised LSB-first, then in_eop
//     -> rx_done, crc_ok=1, stuff_err=0, len_err=0, pkt_out=64'h40aa11b7682df6d8.
//  2. Stuff-heavy packet: payload 64'hffffff0000000000 with correct CRC and 4 stuffed zeros in the 24-ones run
//     -> crc_ok=1, pkt_out matches the payload, bit_cnt=80.
//  3. Repeat case 1 with bit 10 of the payload flipped -> crc_ok=0, len_err=0, pkt_out keeps the prior value.
//  4. Seven consecutive 1s on the bus (stuffed position = 1), then in_eop 3 bits later
//     -> stuff_err=1, crc_ok=0, rx_busy high until rx_done.
//  5. Truncated packet (79 accepted bits) then in_eop -> len_err=1, crc_ok=0.
//     An 81-bit packet -> ERR, len_err=1.
//  6. Assert reset_n=0 after 40 bits of a packet, then send a full good packet
//     -> no rx_done for the aborted packet; the second packet gives crc_ok=1.

Source files
------------

// File: rtl/bit_unstuff_crc16_rx_if.sv
// ---------------------------------------------------------------------------
// bit_unstuff_crc16_rx_if
// Bundles the receive-side bus stream and the per-packet status returned to
// the protocol handler.
//   in_bit / in_valid / in_eop : decoded bus bit, its qualifier, and the
//                                end-of-packet pulse (driven by the master)
//   pkt_out                    : received payload, first bus bit in bit 0
//   rx_busy / rx_done          : reception in progress / 1-cycle done pulse
//   crc_ok / stuff_err / len_err : packet status, held until the next packet
// The master modport is the bit source and the slave modport is the receiver.
// ---------------------------------------------------------------------------
interface bit_unstuff_crc16_rx_if #(
   parameter int DATA_BITS = 64
);
   logic                 in_bit;
   logic                 in_valid;
   logic                 in_eop;
   logic [DATA_BITS-1:0] pkt_out;
   logic                 rx_busy;
   logic                 rx_done;
   logic                 crc_ok;
   logic                 stuff_err;
   logic                 len_err;

   modport master (
      output in_bit, in_valid, in_eop,
      input  pkt_out, rx_busy, rx_done, crc_ok, stuff_err, len_err
   );

   modport slave (
      input  in_bit, in_valid, in_eop,
      output pkt_out, rx_busy, rx_done, crc_ok, stuff_err, len_err
   );
endinterface

// File: rtl/bit_unstuff_crc16_rx.sv
// ---------------------------------------------------------------------------
// bit_unstuff_crc16_rx
// Receive side of the CRC16 encoder + bit stuffer. Takes the decoded serial
// body of a DATA packet (payload followed by the 16-bit CRC field), drops
// stuffed zeros, runs the USB CRC16 (x^16+x^15+x^2+1, preset all ones) over
// every accepted bit and deserialises the payload. One rx_done pulse with
// status is issued the cycle after each in_eop.
// Ports:
//   clock   : system clock, all state on the rising edge
//   reset_n : asynchronous active-low reset
//   bus     : slave side of bit_unstuff_crc16_rx_if (bit stream in, status out)
// ---------------------------------------------------------------------------
module bit_unstuff_crc16_rx #(
   parameter int DATA_BITS = 64
) (
   input  logic                        clock,
   input  logic                        reset_n,
   bit_unstuff_crc16_rx_if.slave       bus
);
   localparam int PKT_BITS = DATA_BITS + 16;
   localparam int CNT_W    = $clog2(PKT_BITS + 18);

   localparam logic [CNT_W-1:0] CNT_FULL     = CNT_W'(PKT_BITS);
   localparam logic [CNT_W-1:0] CNT_SAT      = CNT_W'(PKT_BITS + 1);
   localparam logic [15:0]      CRC_INIT     = 16'hFFFF;
   localparam logic [15:0]      CRC_POLY     = 16'h8005;
   localparam logic [15:0]      CRC_RESIDUAL = 16'h800D;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RECV = 2'd1,
      ERR  = 2'd2
   } state_t;

   // One serial CRC16 step, MSB of the register is the highest-order term.
   function automatic logic [15:0] crc16_step(input logic [15:0] crc, input logic b);
      logic fb;
      fb         = crc[15] ^ b;
      crc16_step = {crc[14:0], 1'b0} ^ (fb ? CRC_POLY : 16'h0000);
   endfunction

   state_t               state_r, state_s;
   logic [2:0]           ones_r, ones_s;
   logic [CNT_W-1:0]     cnt_r, cnt_s;
   logic [15:0]          crc_r, crc_s;
   logic [PKT_BITS-1:0]  sr_r, sr_s;
   logic                 stuff_r, stuff_s;
   logic                 ovf_r, ovf_s;
   logic                 start_s;
   logic                 len_s;
   logic                 ok_s;

   logic [DATA_BITS-1:0] pkt_r;
   logic                 busy_r;
   logic                 done_r;
   logic                 crc_ok_r;
   logic                 stuff_err_r;
   logic                 len_err_r;

   // Next-state: packet start, unstuffing, CRC/shift update and EOP evaluation.
   always_comb begin
      state_s = state_r;
      ones_s  = ones_r;
      cnt_s   = cnt_r;
      crc_s   = crc_r;
      sr_s    = sr_r;
      stuff_s = stuff_r;
      ovf_s   = ovf_r;
      start_s = 1'b0;
      len_s   = 1'b0;
      ok_s    = 1'b0;

      // In IDLE the working values are presented as the packet preset, so a
      // bit arriving here is processed as the first bit of a fresh packet and
      // an EOP with no bits is judged as a zero-length packet.
      case (state_r)
         IDLE: begin
            ones_s  = 3'd0;
            cnt_s   = '0;
            crc_s   = CRC_INIT;
            stuff_s = 1'b0;
            ovf_s   = 1'b0;
            if (bus.in_valid) begin
               start_s = 1'b1;
               state_s = RECV;
            end else begin
               start_s = 1'b0;
               state_s = IDLE;
            end
         end
         RECV:    state_s = RECV;
         ERR:     state_s = ERR;
         default: state_s = IDLE;
      endcase

      if (bus.in_valid && ((state_r == IDLE) || (state_r == RECV))) begin
         if (ones_s == 3'd6) begin
            // Six ones in a row: this position must be a stuffed zero.
            if (bus.in_bit) begin
               stuff_s = 1'b1;
               state_s = ERR;
            end else begin
               ones_s = 3'd0;
            end
         end else begin
            ones_s = bus.in_bit ? (ones_s + 3'd1) : 3'd0;
            sr_s   = {bus.in_bit, sr_s[PKT_BITS-1:1]};
            crc_s  = crc16_step(crc_s, bus.in_bit);
            if (cnt_s == CNT_FULL) begin
               ovf_s   = 1'b1;
               state_s = ERR;
            end else begin
               ovf_s = ovf_s;
            end
            cnt_s = (cnt_s == CNT_SAT) ? cnt_s : (cnt_s + CNT_W'(1));
         end
      end else begin
         ones_s = ones_s;
      end

      // EOP is judged after this cycle's bit has been folded in.
      if (bus.in_eop) begin
         len_s   = (cnt_s != CNT_FULL) || ovf_s;
         ok_s    = !len_s && !stuff_s && (crc_s == CRC_RESIDUAL);
         state_s = IDLE;
      end else begin
         len_s = 1'b0;
         ok_s  = 1'b0;
      end
   end

   // FSM and working registers.
   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         state_r <= IDLE;
         ones_r  <= 3'd0;
         cnt_r   <= '0;
         crc_r   <= CRC_INIT;
         sr_r    <= '0;
         stuff_r <= 1'b0;
         ovf_r   <= 1'b0;
      end else begin
         state_r <= state_s;
         ones_r  <= ones_s;
         cnt_r   <= cnt_s;
         crc_r   <= crc_s;
         sr_r    <= sr_s;
         stuff_r <= stuff_s;
         ovf_r   <= ovf_s;
      end
   end

   // Registered status outputs; status holds until the next packet starts.
   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         pkt_r       <= '0;
         busy_r      <= 1'b0;
         done_r      <= 1'b0;
         crc_ok_r    <= 1'b0;
         stuff_err_r <= 1'b0;
         len_err_r   <= 1'b0;
      end else begin
         done_r <= bus.in_eop;
         busy_r <= (state_s != IDLE);
         if (bus.in_eop) begin
            crc_ok_r    <= ok_s;
            stuff_err_r <= stuff_s;
            len_err_r   <= len_s;
            if (ok_s) begin
               pkt_r <= sr_s[DATA_BITS-1:0];
            end else begin
               pkt_r <= pkt_r;
            end
         end else if (start_s) begin
            crc_ok_r    <= 1'b0;
            stuff_err_r <= 1'b0;
            len_err_r   <= 1'b0;
         end else begin
            crc_ok_r    <= crc_ok_r;
            stuff_err_r <= stuff_err_r;
            len_err_r   <= len_err_r;
         end
      end
   end

   assign bus.pkt_out   = pkt_r;
   assign bus.rx_busy   = busy_r;
   assign bus.rx_done   = done_r;
   assign bus.crc_ok    = crc_ok_r;
   assign bus.stuff_err = stuff_err_r;
   assign bus.len_err   = len_err_r;

endmodule

// File: tb/tb_bit_unstuff_crc16_rx.sv
// ---------------------------------------------------------------------------
// tb_bit_unstuff_crc16_rx
// Packets are described as lists of accepted bits (payload LSB first, then the
// CRC field), stuffed into bus bit lists, and driven with random gaps. The
// expected status of each packet is derived from its bus bit list; a per-cycle
// compare process checks every output against those expectations.
// ---------------------------------------------------------------------------
module tb_bit_unstuff_crc16_rx;
   localparam int DB = 64;

   localparam logic [DB-1:0] P1 = 64'h40aa11b7682df6d8;
   localparam logic [DB-1:0] P2 = 64'hffffff0000000000;

   logic clock = 1'b0;
   logic reset_n;

   bit_unstuff_crc16_rx_if #(.DATA_BITS(DB)) bus_if ();

   bit_unstuff_crc16_rx #(.DATA_BITS(DB)) dut (
      .clock   (clock),
      .reset_n (reset_n),
      .bus     (bus_if)
   );

   always #5 clock = ~clock;

   typedef struct {
      bit            ok;
      bit            serr;
      bit            lerr;
      logic [DB-1:0] pay;
   } res_t;

   int   checks = 0;
   int   errors = 0;
   bit   acc_q[$];
   bit   bus_q[$];
   res_t res_q[$];

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s at %0t: got %h, expected %h", name, $time, act, exp);
      end
   endtask

   // CRC field by polynomial long division: message (first bit = highest
   // degree) times x^16, top 16 message bits complemented for the all-ones
   // preset; the field is the complemented remainder, highest term sent first.
   function automatic logic [15:0] crc16_field(input logic [DB-1:0] p);
      logic [DB+15:0] m;
      logic [15:0]    f;
      m = '0;
      for (int i = 0; i < DB; i++) m[DB+15-i] = p[i] ^ (i < 16);
      for (int k = DB + 15; k >= 16; k--) begin
         if (m[k]) m[k -: 17] = m[k -: 17] ^ 17'h18005;
      end
      for (int i = 0; i < 16; i++) f[i] = ~m[15-i];
      return f;
   endfunction

   task automatic make_good(input logic [DB-1:0] p);
      logic [15:0] f;
      f = crc16_field(p);
      acc_q.delete();
      for (int i = 0; i < DB; i++) acc_q.push_back(p[i]);
      for (int i = 0; i < 16; i++) acc_q.push_back(f[i]);
   endtask

   // Transmitter-side stuffing: a 0 follows every run of six 1s.
   task automatic build_bus();
      int run;
      run = 0;
      bus_q.delete();
      foreach (acc_q[i]) begin
         bus_q.push_back(acc_q[i]);
         run = acc_q[i] ? run + 1 : 0;
         if (run == 6) begin
            bus_q.push_back(1'b0);
            run = 0;
         end
      end
   endtask

   // Expected packet status from the bus bit list.
   function automatic res_t model_rx();
      res_t        r;
      bit          acc[$];
      int          run;
      bit          stop;
      logic [15:0] fld;
      run    = 0;
      stop   = 1'b0;
      r.serr = 1'b0;
      for (int i = 0; i < bus_q.size() && !stop; i++) begin
         if (run == 6) begin
            if (bus_q[i]) begin
               r.serr = 1'b1;
               stop   = 1'b1;
            end
            run = 0;
         end else begin
            acc.push_back(bus_q[i]);
            run = bus_q[i] ? run + 1 : 0;
            if (acc.size() > DB + 16) stop = 1'b1;
         end
      end
      r.lerr = (acc.size() != DB + 16);
      r.pay  = '0;
      fld    = '0;
      if (!r.lerr) begin
         for (int i = 0; i < DB; i++) r.pay[i] = acc[i];
         for (int i = 0; i < 16; i++) fld[i] = acc[DB+i];
      end
      r.ok = !r.lerr && !r.serr && (fld == crc16_field(r.pay));
      return r;
   endfunction

   task automatic drive(input bit v, input bit b, input bit e);
      bus_if.in_valid = v;
      bus_if.in_bit   = b;
      bus_if.in_eop   = e;
      @(posedge clock);
      #1;
      bus_if.in_valid = 1'b0;
      bus_if.in_bit   = 1'b0;
      bus_if.in_eop   = 1'b0;
   endtask

   task automatic send_pkt(input bit eop_last, input int gap_max);
      res_t r;
      int   n;
      r = model_rx();
      n = bus_q.size();
      for (int i = 0; i < n; i++) begin
         repeat ($urandom_range(gap_max, 0)) drive(1'b0, 1'b0, 1'b0);
         if ((i == n - 1) && eop_last) begin
            res_q.push_back(r);
            drive(1'b1, bus_q[i], 1'b1);
         end else begin
            drive(1'b1, bus_q[i], 1'b0);
         end
      end
      if (!eop_last || (n == 0)) begin
         res_q.push_back(r);
         drive(1'b0, 1'b0, 1'b1);
      end
   endtask

   task automatic chk_status(input string tag, input bit ok, input bit serr, input bit lerr,
                             input logic [DB-1:0] pkt);
      chk({tag, "_crc_ok"},    64'(bus_if.crc_ok),    64'(ok));
      chk({tag, "_stuff_err"}, 64'(bus_if.stuff_err), 64'(serr));
      chk({tag, "_len_err"},   64'(bus_if.len_err),   64'(lerr));
      chk({tag, "_pkt_out"},   64'(bus_if.pkt_out),   64'(pkt));
   endtask

   // Per-cycle comparison of every output against the expectations.
   initial begin
      bit            e_busy, e_done, e_ok, e_serr, e_lerr;
      logic [DB-1:0] e_pkt;
      res_t          r;
      e_busy = 1'b0; e_done = 1'b0; e_ok = 1'b0; e_serr = 1'b0; e_lerr = 1'b0;
      e_pkt  = '0;
      forever begin
         @(negedge clock);
         if (!reset_n) begin
            e_busy = 1'b0; e_done = 1'b0; e_ok = 1'b0; e_serr = 1'b0; e_lerr = 1'b0;
            e_pkt  = '0;
         end
         chk("rx_done",   64'(bus_if.rx_done),   64'(e_done));
         chk("rx_busy",   64'(bus_if.rx_busy),   64'(e_busy));
         chk("crc_ok",    64'(bus_if.crc_ok),    64'(e_ok));
         chk("stuff_err", 64'(bus_if.stuff_err), 64'(e_serr));
         chk("len_err",   64'(bus_if.len_err),   64'(e_lerr));
         chk("pkt_out",   64'(bus_if.pkt_out),   64'(e_pkt));
         if (reset_n) begin
            // Expectations for the cycle after the coming edge.
            e_done = bus_if.in_eop;
            if (bus_if.in_eop) begin
               if (res_q.size() == 0) begin
                  chk("result_available", 64'd0, 64'd1);
               end else begin
                  r      = res_q.pop_front();
                  e_ok   = r.ok;
                  e_serr = r.serr;
                  e_lerr = r.lerr;
                  if (r.ok) e_pkt = r.pay;
               end
               e_busy = 1'b0;
            end else if (bus_if.in_valid) begin
               if (!e_busy) begin
                  e_ok = 1'b0; e_serr = 1'b0; e_lerr = 1'b0;
               end
               e_busy = 1'b1;
            end
         end
      end
   end

   initial begin
      logic [DB-1:0] p;
      int            mode, pos, d;
      reset_n         = 1'b0;
      bus_if.in_valid = 1'b0;
      bus_if.in_bit   = 1'b0;
      bus_if.in_eop   = 1'b0;
      repeat (3) @(posedge clock);
      #1 reset_n = 1'b1;
      drive(1'b0, 1'b0, 1'b0);

      // The reference CRC must reproduce the known field of the sample packet.
      chk("model_crc_field", 64'(crc16_field(P1)), 64'h544a);

      // Good packet.
      make_good(P1); build_bus(); send_pkt(1'b0, 0);
      chk_status("good", 1'b1, 1'b0, 1'b0, P1);

      // Stuff-heavy packet: 24-ones run needs four stuffed zeros.
      make_good(P2); build_bus(); send_pkt(1'b0, 1);
      chk_status("stuffy", 1'b1, 1'b0, 1'b0, P2);

      // Payload bit 10 flipped: CRC fails, payload keeps the previous value.
      make_good(P1); acc_q[10] = ~acc_q[10]; build_bus(); send_pkt(1'b0, 0);
      chk_status("flip10", 1'b0, 1'b0, 1'b0, P2);

      // Seven ones on the bus, three more bits, then EOP.
      bus_q = '{1, 1, 1, 1, 1, 1, 1, 0, 1, 0};
      send_pkt(1'b0, 0);
      chk_status("stuff1", 1'b0, 1'b1, 1'b1, P2);

      // 79 and 81 accepted bits.
      make_good(P1); void'(acc_q.pop_back()); build_bus(); send_pkt(1'b0, 0);
      chk_status("short79", 1'b0, 1'b0, 1'b1, P2);
      make_good(P1); acc_q.push_back(1'b0); build_bus(); send_pkt(1'b1, 0);
      chk_status("long81", 1'b0, 1'b0, 1'b1, P2);

      // EOP alone in IDLE, then a single bit coinciding with EOP.
      bus_q.delete(); send_pkt(1'b0, 0);
      chk_status("eop_only", 1'b0, 1'b0, 1'b1, P2);
      bus_q = '{1}; send_pkt(1'b1, 0);
      chk_status("bit_eop", 1'b0, 1'b0, 1'b1, P2);

      // Reset after 40 bus bits, then a full good packet.
      make_good(P2); build_bus();
      for (int i = 0; i < 40; i++) drive(1'b1, bus_q[i], 1'b0);
      reset_n = 1'b0;
      repeat (2) drive(1'b0, 1'b0, 1'b0);
      reset_n = 1'b1;
      drive(1'b0, 1'b0, 1'b0);
      make_good(P1); build_bus(); send_pkt(1'b0, 0);
      chk_status("after_reset", 1'b1, 1'b0, 1'b0, P1);

      // Random packets with assorted faults, gaps and back-to-back starts.
      for (int n = 0; n < 40; n++) begin
         p = {$urandom, $urandom};
         if ($urandom_range(2, 0) == 0) p = p | {$urandom, $urandom} | {$urandom, $urandom};
         mode = $urandom_range(5, 0);
         make_good(p);
         if (mode == 3) begin
            pos        = $urandom_range(DB + 15, 0);
            acc_q[pos] = ~acc_q[pos];
         end else if (mode == 4) begin
            d = $urandom_range(4, 1);
            if ($urandom_range(1, 0) == 1) begin
               repeat (d) void'(acc_q.pop_back());
            end else begin
               repeat (d) acc_q.push_back(1'($urandom_range(1, 0)));
            end
         end
         build_bus();
         if (mode == 5) begin
            pos = $urandom_range(bus_q.size() - 1, 0);
            repeat (7) bus_q.insert(pos, 1'b1);
         end
         send_pkt(1'($urandom_range(1, 0)), $urandom_range(2, 0));
         repeat ($urandom_range(2, 0)) drive(1'b0, 1'b0, 1'b0);
      end

      repeat (3) drive(1'b0, 1'b0, 1'b0);
      chk("results_drained", 64'(res_q.size()), 64'd0);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
